// File: rtl/jtframe_tilemap_lbuf_pkg.sv
// Shared definitions for the tilemap line buffer: pixel width, RAM geometry,
// line sequencer state encoding and the playback address helper.
package jtframe_tilemap_lbuf_pkg;

  localparam int LBUF_DW = 11;
  localparam int LBUF_AW = 9;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_STOP  = 2'd1;
  localparam state_t ST_START = 2'd2;
  localparam state_t ST_BUSY  = 2'd3;

  // 255 - rc for an 8-bit counter is simply its bitwise complement
  function automatic logic [7:0] play_addr(input logic [7:0] rc, input logic flip);
    return flip ? ~rc : rc;
  endfunction

endpackage

// File: rtl/jtframe_tilemap_lbuf_ram.sv
// Simple dual-port RAM: one write port, one registered read port, single clock.
module jtframe_tilemap_lbuf_ram
  import jtframe_tilemap_lbuf_pkg::*;
#(
  parameter int DW = LBUF_DW,
  parameter int AW = LBUF_AW
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  // NOTE: the array has no reset so it maps onto block RAM; the fill levels
  // in the parent decide which stored words are visible.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/jtframe_tilemap_lbuf.sv
// Double-buffered line buffer: sequences the tilemap renderer once per line,
// collects its writes into one bank and plays the other bank out at pixel rate.
module jtframe_tilemap_lbuf
  import jtframe_tilemap_lbuf_pkg::*;
#(
  parameter int DW = LBUF_DW
) (
  input  logic          rst,
  input  logic          clk,
  input  logic          pxl_cen,
  input  logic          line,
  input  logic          LHBL,
  input  logic [8:0]    vrender,
  input  logic          flip,
  output logic [8:0]    tm_vrender,
  output logic          tm_start,
  output logic          tm_stop,
  input  logic          tm_done,
  input  logic [8:0]    buf_addr,
  input  logic [DW-1:0] buf_data,
  input  logic          buf_wr,
  output logic [DW-1:0] pxl,
  output logic          overrun
);

  state_t st, st_nx;

  logic            wb;
  logic            busy;
  logic [1:0][8:0] lvl;
  logic            we;
  logic [8:0]      wr_end;

  logic [7:0]      rc;
  logic [7:0]      pa;
  logic [8:0]      rd_lvl;
  logic            rd_en;
  logic            rd_pend;
  logic            vis_q;
  logic [DW-1:0]   rd_data;

  // ---------------- line sequencer ----------------
  // NOTE: every clocked block uses non-blocking assignments so all registers
  // update together from the values seen before the edge.
  always_ff @(posedge clk) begin
    if (rst) st <= ST_IDLE;
    else     st <= st_nx;
  end

  // NOTE: defaults at the top of each combinational block keep every path
  // assigned, so no latch is inferred.
  always_comb begin
    st_nx = st;
    case (st)
      ST_STOP:  st_nx = ST_START;
      ST_START: st_nx = ST_BUSY;
      ST_BUSY:  if (tm_done) st_nx = ST_IDLE;
      default:  st_nx = ST_IDLE;
    endcase
    if (line) st_nx = ST_STOP;
  end

  always_comb begin
    tm_stop  = 1'b0;
    tm_start = 1'b0;
    case (st)
      ST_STOP:  tm_stop  = busy;
      ST_START: tm_start = 1'b1;
      default:  ;
    endcase
  end

  // ---------------- write side ----------------
  // The STOP cycle is excluded so late writes never land in the bank that is
  // about to become visible.
  assign we     = busy && (st != ST_STOP) && buf_wr && !buf_addr[8];
  assign wr_end = {1'b0, buf_addr[7:0]} + 9'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      wb         <= 1'b0;
      busy       <= 1'b0;
      lvl        <= '0;
      tm_vrender <= '0;
      overrun    <= 1'b0;
    end else begin
      if (we && (wr_end > lvl[wb])) lvl[wb] <= wr_end;
      case (st)
        ST_STOP: begin
          tm_vrender <= vrender;
          wb         <= ~wb;
          lvl[~wb]   <= '0;
          busy       <= 1'b0;
          if (busy) overrun <= 1'b1;
        end
        ST_START: busy <= 1'b1;
        // a new line beats a finishing renderer, so it still gets its abort
        ST_BUSY:  if (tm_done && !line) busy <= 1'b0;
        default:  ;
      endcase
    end
  end

  // ---------------- read side ----------------
  assign pa     = play_addr(rc, flip);
  assign rd_en  = pxl_cen && LHBL;
  assign rd_lvl = lvl[~wb];

  always_ff @(posedge clk) begin
    if (rst) begin
      rc      <= '0;
      rd_pend <= 1'b0;
      vis_q   <= 1'b0;
      pxl     <= '0;
    end else begin
      if (line)       rc <= '0;
      else if (rd_en) rc <= rc + 8'd1;
      if (rd_en) vis_q <= ({1'b0, pa} < rd_lvl);
      // the last active read of a line drains on the first blank enable
      if (pxl_cen) begin
        rd_pend <= LHBL;
        if (rd_pend) pxl <= vis_q ? rd_data : '0;
      end
    end
  end

  jtframe_tilemap_lbuf_ram #(
    .DW(DW),
    .AW(LBUF_AW)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr ({wb, buf_addr[7:0]}),
    .wdata (buf_data),
    .re    (rd_en),
    .raddr ({~wb, pa}),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_jtframe_tilemap_lbuf.sv
// Self-checking bench: directed scan lines against a bank/level model of the
// line buffer, with a continuous pixel-stream comparison.
module tb_jtframe_tilemap_lbuf;

  localparam int DW = 11;

  logic          rst = 1'b1;
  logic          clk = 1'b0;
  logic          pxl_cen = 1'b0;
  logic          line = 1'b0;
  logic          LHBL = 1'b0;
  logic [8:0]    vrender = '0;
  logic          flip = 1'b0;
  logic [8:0]    tm_vrender;
  logic          tm_start;
  logic          tm_stop;
  logic          tm_done = 1'b0;
  logic [8:0]    buf_addr = '0;
  logic [DW-1:0] buf_data = '0;
  logic          buf_wr = 1'b0;
  logic [DW-1:0] pxl;
  logic          overrun;

  jtframe_tilemap_lbuf #(.DW(DW)) dut (
    .rst        (rst),
    .clk        (clk),
    .pxl_cen    (pxl_cen),
    .line       (line),
    .LHBL       (LHBL),
    .vrender    (vrender),
    .flip       (flip),
    .tm_vrender (tm_vrender),
    .tm_start   (tm_start),
    .tm_stop    (tm_stop),
    .tm_done    (tm_done),
    .buf_addr   (buf_addr),
    .buf_data   (buf_data),
    .buf_wr     (buf_wr),
    .pxl        (pxl),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  // Two banks of 256 pixels with a fill level each; the bank being written is
  // m_wb and the bank shown is the other one.
  logic [DW-1:0] m_mem [2][256];
  int            m_lvl [2];
  bit            m_wb;
  bit            r_busy;
  bit            m_ovr;
  logic [DW-1:0] m_pxl = '0;
  logic [DW-1:0] m_q [$];
  int            m_k = 0;

  function automatic logic [DW-1:0] model_pixel(input int k, input logic f);
    int pa;
    int rb;
    pa = f ? 255 - k : k;
    rb = m_wb ? 0 : 1;
    return (pa < m_lvl[rb]) ? m_mem[rb][pa] : '0;
  endfunction

  task automatic model_write(input int a, input logic [DW-1:0] d);
    m_mem[m_wb][a] = d;
    if (a + 1 > m_lvl[m_wb]) m_lvl[m_wb] = a + 1;
  endtask

  // Pixel k (k-th active enable since line) shows up one enable later.
  always @(posedge clk) begin
    if (rst) begin
      m_pxl = '0;
      m_q.delete();
      m_k = 0;
    end else begin
      if (pxl_cen) begin
        if (m_q.size() > 0) m_pxl = m_q.pop_front();
        if (LHBL) m_q.push_back(model_pixel(m_k, flip));
      end
      if (line) m_k = 0;
      else if (pxl_cen && LHBL) m_k = (m_k + 1) % 256;
    end
  end

  always @(negedge clk) begin
    if (cmp_on) check("pxl_stream", 32'(pxl), 32'(m_pxl));
  end

  // ---------------- stimulus tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; line = 1'b0; buf_wr = 1'b0; tm_done = 1'b0; pxl_cen = 1'b0; LHBL = 1'b0;
    @(negedge clk);
    @(negedge clk);
    m_wb = 1'b0; m_lvl[0] = 0; m_lvl[1] = 0; r_busy = 1'b0; m_ovr = 1'b0;
    check("rst_tm_start", 32'(tm_start), 0);
    check("rst_tm_stop", 32'(tm_stop), 0);
    check("rst_tm_vrender", 32'(tm_vrender), 0);
    check("rst_pxl", 32'(pxl), 0);
    check("rst_overrun", 32'(overrun), 0);
    rst = 1'b0;
  endtask

  // Returns between the START cycle and the first BUSY cycle.
  task automatic pulse_line(input logic [8:0] vr, input bit done_too, input bit wr_in_stop);
    bit exp_stop;
    @(negedge clk);
    vrender = vr; line = 1'b1;
    if (done_too) tm_done = 1'b1;
    @(negedge clk);
    line = 1'b0; tm_done = 1'b0;
    exp_stop = r_busy;
    check("tm_stop_n1", 32'(tm_stop), 32'(exp_stop));
    check("tm_start_n1", 32'(tm_start), 0);
    if (wr_in_stop) begin
      buf_wr = 1'b1; buf_addr = 9'd5; buf_data = 11'h7FF;
    end
    if (exp_stop) m_ovr = 1'b1;
    @(negedge clk);
    buf_wr = 1'b0;
    check("tm_start_n2", 32'(tm_start), 1);
    check("tm_stop_n2", 32'(tm_stop), 0);
    check("tm_vrender", 32'(tm_vrender), 32'(vr));
    check("overrun", 32'(overrun), 32'(m_ovr));
    m_wb = ~m_wb;
    m_lvl[m_wb] = 0;
    r_busy = 1'b1;
  endtask

  task automatic render(input int n, input logic [DW-1:0] base, input bit done);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      buf_wr = 1'b1; buf_addr = 9'(i); buf_data = base | DW'(i);
      model_write(i, base | DW'(i));
    end
    @(negedge clk);
    buf_wr = 1'b0;
    if (done) begin
      tm_done = 1'b1;
      @(negedge clk);
      tm_done = 1'b0;
      r_busy = 1'b0;
    end
  endtask

  // Out-of-range writes while busy, then in-range writes after tm_done.
  task automatic render_filtered();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      buf_wr = 1'b1; buf_addr = 9'h100 + 9'(i); buf_data = 11'h7AA;
    end
    @(negedge clk);
    buf_wr = 1'b0; tm_done = 1'b1;
    @(negedge clk);
    tm_done = 1'b0; r_busy = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      buf_wr = 1'b1; buf_addr = 9'(i); buf_data = 11'h555;
    end
    @(negedge clk);
    buf_wr = 1'b0;
  endtask

  // 256 active enables on alternate clocks, then two enables in blank.
  task automatic play(input bit f, input int lit_k, input logic [DW-1:0] lit_v);
    @(negedge clk);
    flip = f; LHBL = 1'b1;
    for (int i = 0; i < 258; i++) begin
      if (i == 256) LHBL = 1'b0;
      pxl_cen = 1'b1;
      @(negedge clk);
      pxl_cen = 1'b0;
      if (i == lit_k + 1) check("pxl_literal", 32'(pxl), 32'(lit_v));
      @(negedge clk);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    cmp_on = 1'b1;

    // L1: idle start, full render; empty bank played
    pulse_line(9'h05A, 1'b0, 1'b0);
    fork
      render(256, 11'h000, 1'b1);
      play(1'b0, 200, 11'h000);
    join

    // L2: play 0..255, render full again
    pulse_line(9'h05B, 1'b0, 1'b0);
    fork
      render(256, 11'h000, 1'b1);
      play(1'b0, 10, 11'd10);
    join

    // L3: flipped playback 255..0, renderer left unfinished after 100 writes
    pulse_line(9'h05C, 1'b0, 1'b0);
    fork
      render(100, 11'h400, 1'b0);
      play(1'b1, 0, 11'd255);
    join

    // L4: abort, late write in STOP, partial bank played, filtered writes
    pulse_line(9'h0C0, 1'b0, 1'b1);
    fork
      render_filtered();
      play(1'b0, 99, 11'h463);
    join

    // L5: nothing was stored on L4
    pulse_line(9'h0C1, 1'b0, 1'b0);
    fork
      render(30, 11'h200, 1'b0);
      play(1'b0, 0, 11'h000);
    join

    // L6: tm_done together with line, flipped playback of L5's 30 pixels
    pulse_line(9'h1F3, 1'b1, 1'b0);
    fork
      render(50, 11'h300, 1'b0);
      play(1'b1, 255, 11'h200);
    join

    // reset while the renderer is still busy
    do_reset();

    // L7: levels were cleared, playback is all transparent
    pulse_line(9'h010, 1'b0, 1'b0);
    play(1'b0, 3, 11'h000);

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
